// File: rtl/bk_pkg.sv
// Shared parameters and types for the pipelined Brent-Kung subtractor.
// Operand width defaults and the split of prefix levels between stages 1 and 2.
package bk_pkg;

    localparam int unsigned N_DEF         = 16;
    localparam int unsigned L_DEF         = $clog2(N_DEF);
    localparam int unsigned S1_LEVELS_DEF = (L_DEF + 1) / 2;

    // Propagate/generate pair; p is the MSB so {p, g} concatenations map directly.
    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Up-sweep levels done in stage 1: ceil(l / 2).
    function automatic int unsigned s1_levels(input int unsigned l);
        return (l + 1) / 2;
    endfunction

endpackage

// File: rtl/bk_black_cell.sv
// Brent-Kung prefix node: combines a higher span with the adjacent lower span.
// G = Gh | Ph & Gl, P = Ph & Pl.
module bk_black_cell
    import bk_pkg::*;
(
    input  pg_t i_hi,
    input  pg_t i_lo,
    output pg_t o_pg
);

    assign o_pg.g = i_hi.g | (i_hi.p & i_lo.g);
    assign o_pg.p = i_hi.p & i_lo.p;

endmodule

// File: rtl/brent_sub_pipe.sv
// Three-stage pipelined A - B - bin over a Brent-Kung prefix tree with valid/ready
// handshake on both ends; computed as a + ~b + ~bin, borrow-out is the inverted carry.
module brent_sub_pipe
    import bk_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    localparam int unsigned L  = $clog2(N);
    localparam int unsigned L1 = s1_levels(L);

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic r_v1, r_v2, r_v3;
    logic w_adv1, w_adv2, w_adv3, w_acc;

    assign w_adv3    = r_v3 & out_ready;
    assign w_adv2    = r_v2 & (~r_v3 | w_adv3);
    assign w_adv1    = r_v1 & (~r_v2 | w_adv2);
    assign in_ready  = ~r_v1 | w_adv1;
    assign w_acc     = in_valid & in_ready;
    assign out_valid = r_v3;

    // A stage reloads whenever it is empty or draining, so bubbles collapse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (in_ready)          r_v1 <= in_valid;
            if (~r_v2 | w_adv2)    r_v2 <= w_adv1;
            if (~r_v3 | w_adv3)    r_v3 <= w_adv2;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: bitwise p/g and the lower up-sweep levels
    // ------------------------------------------------------------------
    pg_t [N-1:0] w_s1_base;

    for (genvar i = 0; i < N; i++) begin : g_s1_base
        assign w_s1_base[i] = {a[i] ~^ b[i], a[i] & ~b[i]};
    end

    for (genvar k = 0; k <= L1; k++) begin : g_s1
        pg_t [N-1:0] w_pg;
        if (k == 0) begin : g_base
            assign w_pg = w_s1_base;
        end else begin : g_up
            for (genvar i = 0; i < N; i++) begin : g_bit
                if (((i + 1) % (1 << k)) == 0) begin : g_node
                    bk_black_cell u_cell (
                        .i_hi (g_s1[k-1].w_pg[i]),
                        .i_lo (g_s1[k-1].w_pg[i - (1 << (k - 1))]),
                        .o_pg (w_pg[i])
                    );
                end else begin : g_pass
                    assign w_pg[i] = g_s1[k-1].w_pg[i];
                end
            end
        end
    end

    logic [N-1:0] r1_p;
    pg_t  [N-1:0] r1_pg;
    logic         r1_c0, r1_am, r1_bm;

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r1_p  <= a ~^ b;
            r1_pg <= g_s1[L1].w_pg;
            r1_c0 <= ~bin;
            r1_am <= a[N-1];
            r1_bm <= b[N-1];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: remaining up-sweep levels, carries at power-of-two positions
    // ------------------------------------------------------------------
    for (genvar k = L1; k <= L; k++) begin : g_s2
        pg_t [N-1:0] w_pg;
        if (k == L1) begin : g_base
            assign w_pg = r1_pg;
        end else begin : g_up
            for (genvar i = 0; i < N; i++) begin : g_bit
                if (((i + 1) % (1 << k)) == 0) begin : g_node
                    bk_black_cell u_cell (
                        .i_hi (g_s2[k-1].w_pg[i]),
                        .i_lo (g_s2[k-1].w_pg[i - (1 << (k - 1))]),
                        .o_pg (w_pg[i])
                    );
                end else begin : g_pass
                    assign w_pg[i] = g_s2[k-1].w_pg[i];
                end
            end
        end
    end

    // Spans rooted at bit 0 fold c0 in: g becomes the carry, p is cleared, so the
    // stage-3 recurrence needs no special case for them.
    pg_t [N-1:0] w_s2_res;

    for (genvar i = 0; i < N; i++) begin : g_s2_res
        if (((i + 1) & i) == 0) begin : g_pow
            assign w_s2_res[i] = {1'b0, g_s2[L].w_pg[i].g | (g_s2[L].w_pg[i].p & r1_c0)};
        end else begin : g_mid
            assign w_s2_res[i] = g_s2[L].w_pg[i];
        end
    end

    logic [N-1:0] r2_p;
    pg_t  [N-1:0] r2_pg;
    logic         r2_c0, r2_am, r2_bm;

    always_ff @(posedge clk) begin
        if (w_adv1) begin
            r2_p  <= r1_p;
            r2_pg <= w_s2_res;
            r2_c0 <= r1_c0;
            r2_am <= r1_am;
            r2_bm <= r1_bm;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: down-sweep from the nearest resolved lower carry
    // ------------------------------------------------------------------
    // Node j-1 spans lowbit(j) bits, so its carry-in sits at j with the low bit cleared.
    logic [N:0]   w_c;
    logic [N-1:0] w_diff;

    always_comb begin
        w_c    = '0;
        w_c[0] = r2_c0;
        for (int j = 1; j <= N; j++) begin
            w_c[j] = r2_pg[j-1].g | (r2_pg[j-1].p & w_c[j - (j & -j)]);
        end
    end

    assign w_diff = r2_p ^ w_c[N-1:0];

    logic [N-1:0] r_diff;
    logic         r_bout, r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_adv2) begin
            r_diff <= w_diff;
            r_bout <= ~w_c[N];
            r_ovf  <= (r2_am ^ r2_bm) & (r2_am ^ w_diff[N-1]);
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_brent_sub_pipe.sv
// Directed bench for brent_sub_pipe (N=16): arithmetic corners, latency, streaming,
// back-pressure, mid-stream reset and a randomized scoreboard phase.
module tb_brent_sub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int          n_cmp = 0;
    int          n_mis = 0;

    logic [15:0] sa   [100];
    logic [15:0] sb   [100];
    logic        sbin [100];
    logic [17:0] e    [100];
    logic [17:0] q    [$];
    logic [17:0] exp_v;
    logic [17:0] prev_out;
    logic        prev_stall;
    int          idx;
    int unsigned w;

    brent_sub_pipe #(.N(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    // Reference: {ovf, bout, diff} from plain 17-bit arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
        logic [16:0] t;
        logic [15:0] d;
        t = {1'b0, x} - {1'b0, y} - {16'b0, c};
        d = t[15:0];
        return {(x[15] ^ y[15]) & (x[15] ^ d[15]), t[16], d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    // Starts and ends #1 after a rising edge; checks the 3-cycle latency too.
    task automatic one_beat(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic c, input logic [15:0] e_d, input logic e_bo,
                            input logic e_ov);
        a = x; b = y; bin = c; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1"}, 32'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_lat2"}, 32'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_diff"}, 32'(diff), 32'(e_d));
        chk({tag, "_bout"}, 32'(bout), 32'(e_bo));
        chk({tag, "_ovf"}, 32'(ovf), 32'(e_ov));
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_diff", 32'(diff), 0);
        chk("rst_bout", 32'(bout), 0);
        chk("rst_ovf", 32'(ovf), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);

        // Arithmetic corners
        one_beat("d5m3",   16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
        one_beat("d0m1",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        one_beat("eqbin",  16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        one_beat("minneg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        one_beat("maxpos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        one_beat("ffbin",  16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        one_beat("zbin",   16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        one_beat("msbeq",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 100; i++) begin
            sa[i]   = 16'(i * 16'h0713 + 16'h02A5);
            sb[i]   = 16'((i * 16'h0B29) ^ 16'h5555);
            sbin[i] = 1'(i & 1);
            e[i]    = model(sa[i], sb[i], sbin[i]);
        end

        // Back-to-back stream, out_ready held high
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    a = sa[i]; b = sb[i]; bin = sbin[i]; in_valid = 1'b1;
                    @(negedge clk);
                    chk("stream_in_ready", 32'(in_ready), 1);
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                w = 0;
                @(negedge clk);
                while (!out_valid && w < 10) begin
                    @(negedge clk);
                    w++;
                end
                for (int j = 0; j < 100; j++) begin
                    if (j > 0) @(negedge clk);
                    chk("stream_valid", 32'(out_valid), 1);
                    chk("stream_data", 32'({ovf, bout, diff}), 32'(e[j]));
                end
            end
        join
        @(posedge clk); #1;

        // Back-pressure: 5 stalled cycles with continuous input
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            a = sa[idx]; b = sb[idx]; bin = sbin[idx]; in_valid = 1'b1;
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), (c < 3) ? 1 : 0);
            if (c >= 3) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_hold", 32'({ovf, bout, diff}), 32'(e[0]));
            end
            if (in_ready) idx++;
            @(posedge clk); #1;
        end
        chk("stall_count", 32'(idx), 3);
        out_ready = 1'b1;
        fork
            begin
                while (idx < 6) begin
                    a = sa[idx]; b = sb[idx]; bin = sbin[idx]; in_valid = 1'b1;
                    @(negedge clk);
                    if (in_ready) idx++;
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    chk("release_valid", 32'(out_valid), 1);
                    chk("release_data", 32'({ovf, bout, diff}), 32'(e[k]));
                end
            end
        join
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_empty", 32'(out_valid), 0);
        @(posedge clk); #1;

        // Reset with beats in flight
        a = 16'h4321; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'h0F00; b = 16'h0100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 1);
        chk("pre_rst_diff", 32'(diff), 32'h4320);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_diff", 32'(diff), 0);
        chk("async_rst_bout", 32'(bout), 0);
        chk("async_rst_ovf", 32'(ovf), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_no_out", 32'(out_valid), 0);
            @(posedge clk); #1;
        end
        one_beat("after_rst", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);

        // Randomized traffic with random back-pressure against the model
        prev_stall = 1'b0;
        prev_out   = '0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            a   = 16'($urandom);
            b   = 16'($urandom);
            bin = 1'($urandom);
            @(negedge clk);
            if (prev_stall) begin
                chk("rnd_hold_valid", 32'(out_valid), 1);
                chk("rnd_hold_data", 32'({ovf, bout, diff}), 32'(prev_out));
            end
            if (out_valid && out_ready) begin
                chk("rnd_sb_nonempty", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_v = q.pop_front();
                    chk("rnd_data", 32'({ovf, bout, diff}), 32'(exp_v));
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, bin));
            prev_stall = out_valid & ~out_ready;
            prev_out   = {ovf, bout, diff};
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) begin
                chk("drain_sb_nonempty", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_v = q.pop_front();
                    chk("drain_data", 32'({ovf, bout, diff}), 32'(exp_v));
                end
            end
            @(posedge clk); #1;
        end
        chk("drain_left", 32'(q.size()), 0);
        chk("drain_idle", 32'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
